// File: rtl/cla_seq_ctrl.sv
// ============================================================================
// cla_seq_ctrl : digit-serial adder sequencing a 2-bit CLA slice, 2 bits/clk
// Revision     : 1.0
// ============================================================================
`default_nettype none

module cla_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] op_a, op_b;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [1:0]       dig_a, dig_b;
  logic             accept, last_digit;
  logic             g0, p0, g1, p1, c1, s0, s1, slice_cout;

  assign accept     = start && (state != RUN);
  assign last_digit = (cnt == LAST);

  // Select the current operand digit; constant slices keep the mux lint-clean.
  always_comb begin
    dig_a = '0;
    dig_b = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt == CW'(i)) begin
        dig_a = op_a[2*i +: 2];
        dig_b = op_b[2*i +: 2];
      end
    end
  end

  // 2-bit carry-lookahead slice; carry-in comes only from the carry register.
  assign g0         = dig_a[0] & dig_b[0];
  assign p0         = dig_a[0] ^ dig_b[0];
  assign g1         = dig_a[1] & dig_b[1];
  assign p1         = dig_a[1] ^ dig_b[1];
  assign c1         = g0 | (p0 & carry);
  assign slice_cout = g1 | (p1 & g0) | (p1 & p0 & carry);
  assign s0         = p0 ^ carry;
  assign s1         = p1 ^ c1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_digit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      op_a  <= a;
      op_b  <= b;
      carry <= cin;
      cnt   <= '0;
      sum   <= '0;
    end else if (state == RUN) begin
      for (int i = 0; i < N; i++) begin
        if (cnt == CW'(i)) sum[2*i +: 2] <= {s1, s0};
      end
      carry <= slice_cout;
      cnt   <= cnt + 1'b1;
      if (last_digit) cout <= slice_cout;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cla_seq_ctrl.sv
// ============================================================================
// tb_cla_seq_ctrl : directed and back-to-back checks of cla_seq_ctrl (WIDTH=8)
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_cla_seq_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst, start, cin;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, cout;
  logic [WIDTH-1:0] sum;

  int vectors    = 0;
  int miscompares = 0;

  cla_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full single addition: accept, 4 RUN cycles, done pulse, then idle.
  task automatic add_check(input string tag, input logic [7:0] xa, input logic [7:0] xb,
                           input logic xc);
    logic [8:0] exp;
    exp   = {1'b0, xa} + {1'b0, xb} + {8'h00, xc};
    a     = xa;
    b     = xb;
    cin   = xc;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = ~xa;
    b     = ~xb;
    cin   = ~xc;
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_nodone"}, {31'd0, done}, 32'd0);
      tick();
    end
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    tick();
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_sum"}, {24'd0, sum}, {24'd0, exp[7:0]});
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, exp[8]});
    tick();
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [7:0] ca, cb, na, nb;
    logic       cc, nc;
    logic [8:0] e;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_sum", {24'd0, sum}, 32'h00);
      chk("rst_cout", {31'd0, cout}, 32'd0);
      tick();
    end

    add_check("ff_01", 8'hFF, 8'h01, 1'b0);
    chk("ff_01_sumv", {24'd0, sum}, 32'h00);
    chk("ff_01_coutv", {31'd0, cout}, 32'd1);

    add_check("a5_5a", 8'hA5, 8'h5A, 1'b1);
    chk("a5_5a_coutv", {31'd0, cout}, 32'd1);
    add_check("12_34", 8'h12, 8'h34, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_sum", {24'd0, sum}, 32'h46);
      chk("hold_cout", {31'd0, cout}, 32'd0);
      chk("hold_done", {31'd0, done}, 32'd0);
      tick();
    end

    // Start re-pulsed mid-run must be ignored.
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_done_k2", {31'd0, done}, 32'd0);
    tick();
    chk("ign_done_k3", {31'd0, done}, 32'd0);
    chk("ign_busy_k3", {31'd0, busy}, 32'd1);
    tick();
    chk("ign_done_k4", {31'd0, done}, 32'd1);
    chk("ign_sum", {24'd0, sum}, 32'h02);
    chk("ign_cout", {31'd0, cout}, 32'd0);
    tick();
    chk("ign_once", {31'd0, done}, 32'd0);
    tick();
    chk("ign_once2", {31'd0, done}, 32'd0);

    // Reset during RUN aborts the operation.
    a = 8'hF0; b = 8'h0F; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_sum", {24'd0, sum}, 32'h00);
    chk("abort_cout", {31'd0, cout}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("abort_nodone", {31'd0, done}, 32'd0);
      tick();
    end
    add_check("03_04", 8'h03, 8'h04, 1'b0);
    chk("03_04_sumv", {24'd0, sum}, 32'h07);

    // Start held high and rst together: rst wins.
    a = 8'h55; b = 8'h55; cin = 1'b1; start = 1'b1; rst = 1'b1;
    tick();
    chk("rst_wins_busy", {31'd0, busy}, 32'd0);
    chk("rst_wins_sum", {24'd0, sum}, 32'h00);
    rst = 1'b0; start = 1'b0;
    tick();

    // Back-to-back with start held high and operands changing every cycle.
    ca = 8'($urandom); cb = 8'($urandom); cc = 1'($urandom);
    a = ca; b = cb; cin = cc; start = 1'b1;
    tick();
    for (int v = 0; v < 1000; v++) begin
      na = 8'($urandom); nb = 8'($urandom); nc = 1'($urandom);
      a = ~ca; b = ~cb; cin = ~cc;
      tick();
      tick();
      a = na; b = nb; cin = nc;
      tick();
      chk("b2b_nodone", {31'd0, done}, 32'd0);
      tick();
      e = {1'b0, ca} + {1'b0, cb} + {8'h00, cc};
      chk("b2b_done", {31'd0, done}, 32'd1);
      chk("b2b_sum", {24'd0, sum}, {24'd0, e[7:0]});
      chk("b2b_cout", {31'd0, cout}, {31'd0, e[8]});
      if (v == 999) start = 1'b0;
      tick();
      ca = na; cb = nb; cc = nc;
    end
    chk("b2b_idle_busy", {31'd0, busy}, 32'd0);
    chk("b2b_idle_done", {31'd0, done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
